mult_div_unit: RTL and testbench

//  Sequential signed multiply/divide responder for the multicycle MIPS core.
//  The control unit issues a one-cycle start with an opcode. The unit iterates for WIDTH cycles, then pulses done.
//  It drives the HI/LO register write data and the DIV0 exception flag.

---
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide unit for the multicycle core.
//   A one-cycle start_i (sampled only when idle) with op_i selects MULT (0) or DIV (1).
//   The unit iterates WIDTH cycles, then pulses done_o with hi_o/lo_o valid.
//   MULT: radix-2 Booth, hi_o/lo_o = full signed 2*WIDTH-bit product.
//   DIV : restoring division on magnitudes, lo_o = quotient, hi_o = remainder,
//         truncating toward zero. Divide by zero pulses div0_o with done_o and
//         leaves hi_o/lo_o unchanged.
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  asynchronous, active-high reset
//   start_i  one-cycle operation request
//   op_i     0 = MULT, 1 = DIV (sampled with start_i)
//   a_i      multiplicand / dividend
//   b_i      multiplier / divisor
//   hi_o     MULT: product[2W-1:W]; DIV: remainder
//   lo_o     MULT: product[W-1:0];  DIV: quotient
//   busy_o   operation in flight
//   done_o   one-cycle completion pulse
//   div0_o   one-cycle divide-by-zero pulse, coincident with done_o
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AccW = 2 * WIDTH + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StDiv,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // MULT: {partial product (W), multiplier (W), booth bit}
  // DIV : {unused (1), remainder (W), dividend/quotient (W)}
  logic [AccW-1:0]   acc_q, acc_d;
  // Multiplicand for MULT, divisor magnitude for DIV.
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              div0_q, div0_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // Booth step
  logic [WIDTH-1:0]  booth_hi;
  logic [WIDTH:0]    booth_sum;

  // Restoring division step
  logic [WIDTH-1:0]  div_rem;
  logic [WIDTH-1:0]  div_quo;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_diff;
  logic              div_qbit;
  logic [WIDTH-1:0]  rem_next;
  logic [WIDTH-1:0]  quo_next;
  logic [WIDTH-1:0]  quo_fix;
  logic [WIDTH-1:0]  rem_fix;

  logic [WIDTH-1:0]  a_abs;
  logic [WIDTH-1:0]  b_abs;

  assign a_abs = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
  assign b_abs = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;

  assign booth_hi = acc_q[AccW-1 -: WIDTH];

  // The add/subtract is done one bit wider so that a most-negative multiplicand
  // cannot overflow the partial product before the arithmetic shift.
  always_comb begin
    booth_sum = {booth_hi[WIDTH-1], booth_hi};
    case (acc_q[1:0])
      2'b01:   booth_sum = {booth_hi[WIDTH-1], booth_hi} + {opb_q[WIDTH-1], opb_q};
      2'b10:   booth_sum = {booth_hi[WIDTH-1], booth_hi} - {opb_q[WIDTH-1], opb_q};
      default: booth_sum = {booth_hi[WIDTH-1], booth_hi};
    endcase
  end

  // Remainder is always below the divisor magnitude (<= 2^(W-1)), so the shifted
  // remainder fits in W bits and bit W of the difference is a clean borrow.
  assign div_rem   = acc_q[2*WIDTH-1:WIDTH];
  assign div_quo   = acc_q[WIDTH-1:0];
  assign div_shift = {div_rem, div_quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_qbit  = ~div_diff[WIDTH];
  assign rem_next  = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {div_quo[WIDTH-2:0], div_qbit};

  assign quo_fix = (sign_a_q ^ sign_b_q) ? (~quo_next + 1'b1) : quo_next;
  assign rem_fix = sign_a_q ? (~rem_next + 1'b1) : rem_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d = '0;
          if (!op_i) begin
            state_d = StMult;
            acc_d   = {{WIDTH{1'b0}}, a_i, 1'b0};
            opb_d   = b_i;
            div0_d  = 1'b0;
          end else if (b_i == '0) begin
            state_d = StFin;
            div0_d  = 1'b1;
          end else begin
            state_d  = StDiv;
            acc_d    = {1'b0, {WIDTH{1'b0}}, a_abs};
            opb_d    = b_abs;
            sign_a_d = a_i[WIDTH-1];
            sign_b_d = b_i[WIDTH-1];
            div0_d   = 1'b0;
          end
        end
      end
      StMult: begin
        acc_d = {booth_sum, acc_q[WIDTH:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StFin;
          hi_d    = booth_sum[WIDTH:1];
          lo_d    = {booth_sum[0], acc_q[WIDTH:2]};
        end
      end
      StDiv: begin
        acc_d = {1'b0, rem_next, quo_next};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StFin;
          hi_d    = rem_fix;
          lo_d    = quo_fix;
        end
      end
      StFin: begin
        state_d = StIdle;
        div0_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StFin);
  assign div0_o = (state_q == StFin) && div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH = 32): directed cases plus
// randomized operations checked against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;
  logic        div0_o;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .div0_o  (div0_o)
  );

  always #5 clk = ~clk;

  // Reference: signed product / truncating quotient and remainder in 64 bits.
  function automatic void model(input logic o, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic ed0, output int elat);
    longint sa, sb, p, q, r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ed0 = 1'b0;
    elat = 33;
    if (!o) begin
      p = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (sb == 0) begin
      ed0 = 1'b1;
      elat = 1;
      eh = prev_hi;
      el = prev_lo;
    end else begin
      q = sa / sb;
      r = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  // Issue one operation when idle; returns results at the done cycle and the
  // cycle number (1 = cycle right after the start edge), 0 on timeout.
  task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output logic rd0, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_o === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 1'($urandom_range(1));
    a     = $urandom;
    b     = $urandom;
    lat = 0;
    rh  = hi_o;
    rl  = lo_o;
    rd0 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done_o === 1'b1) begin
        lat = k;
        rh  = hi_o;
        rl  = lo_o;
        rd0 = div0_o;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (div0_o !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b exp 0", div0_o); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_mult;
    logic [31:0] rh, rl;
    logic rd0;
    int lat;
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, rh, rl, rd0, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency got %0d exp 33", lat); end
    checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult1_hi got %h exp ffffffff", rh); end
    checks++; if (rl !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult1_lo got %h exp ffffffeb", rl); end
    checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL mult1_div0 got %b exp 0", rd0); end
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, rh, rl, rd0, lat);
    checks++; if (rh !== 32'h4000_0000) begin errors++; $display("FAIL mult_minmin_hi got %h exp 40000000", rh); end
    checks++; if (rl !== 32'h0) begin errors++; $display("FAIL mult_minmin_lo got %h exp 0", rl); end
    run_op(1'b0, 32'h0, 32'hDEAD_BEEF, rh, rl, rd0, lat);
    checks++; if ({rh, rl} !== 64'h0) begin errors++; $display("FAIL mult_zero got %h exp 0", {rh, rl}); end
  endtask

  task automatic test_div;
    logic [31:0] rh, rl;
    logic rd0;
    int lat;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, rh, rl, rd0, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    checks++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div1_lo got %h exp fffffffd", rl); end
    checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div1_hi got %h exp ffffffff", rh); end
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, rh, rl, rd0, lat);
    checks++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div2_lo got %h exp fffffffd", rl); end
    checks++; if (rh !== 32'h1) begin errors++; $display("FAIL div2_hi got %h exp 1", rh); end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, rd0, lat);
    checks++; if (rl !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", rl); end
    checks++; if (rh !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 0", rh); end
    checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL div_ovf_div0 got %b exp 0", rd0); end
  endtask

  task automatic test_div0;
    logic [31:0] rh, rl;
    logic rd0;
    int lat;
    // 0x2211 / 0x100 leaves hi = 0x11, lo = 0x22.
    run_op(1'b1, 32'h2211, 32'h100, rh, rl, rd0, lat);
    checks++; if ({rh, rl} !== {32'h11, 32'h22}) begin
      errors++; $display("FAIL div0_setup got %h exp %h", {rh, rl}, {32'h11, 32'h22});
    end
    run_op(1'b1, 32'h1234, 32'h0, rh, rl, rd0, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL div0_latency got %0d exp 1", lat); end
    checks++; if (rd0 !== 1'b1) begin errors++; $display("FAIL div0_flag got %b exp 1", rd0); end
    checks++; if (rh !== 32'h11) begin errors++; $display("FAIL div0_hi_kept got %h exp 11", rh); end
    checks++; if (rl !== 32'h22) begin errors++; $display("FAIL div0_lo_kept got %h exp 22", rl); end
    @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL div0_busy_c2 got %b exp 0", busy_o); end
    checks++; if ({done_o, div0_o} !== 2'b00) begin
      errors++; $display("FAIL div0_pulse_c2 got %b exp 00", {done_o, div0_o});
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] eh, el, rh, rl;
    logic ed0, saw_div0;
    int elat, ndone, first;
    model(1'b0, 32'h0001_2345, 32'hFFFF_F00D, 32'h0, 32'h0, eh, el, ed0, elat);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'h0001_2345;
    b     = 32'hFFFF_F00D;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    first = 0;
    saw_div0 = 1'b0;
    rh = '0;
    rl = '0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (done_o === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = cyc;
          rh = hi_o;
          rl = lo_o;
        end
      end
      if (div0_o === 1'b1) saw_div0 = 1'b1;
      if (cyc == 10) begin
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd99;
        b     = 32'd0;
      end else begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
    checks++; if (first != 33) begin errors++; $display("FAIL ignore_done_cycle got %0d exp 33", first); end
    checks++; if ({rh, rl} !== {eh, el}) begin
      errors++; $display("FAIL ignore_result got %h exp %h", {rh, rl}, {eh, el});
    end
    checks++; if (saw_div0 !== 1'b0) begin errors++; $display("FAIL ignore_div0 got 1 exp 0"); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rh, rl;
    logic rd0, saw_done;
    int lat;
    run_op(1'b0, 32'd3, 32'd5, rh, rl, rd0, lat);
    checks++; if (rl !== 32'd15) begin errors++; $display("FAIL pre_reset_lo got %h exp f", rl); end
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd1000;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({hi_o, lo_o} !== 64'h0) begin
      errors++; $display("FAIL midreset_hilo got %h exp 0", {hi_o, lo_o});
    end
    checks++; if ({busy_o, done_o, div0_o} !== 3'b000) begin
      errors++; $display("FAIL midreset_flags got %b exp 000", {busy_o, done_o, div0_o});
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_o === 1'b1 || busy_o === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done got 1 exp 0"); end
    run_op(1'b1, 32'd100, 32'd7, rh, rl, rd0, lat);
    checks++; if (rl !== 32'd14) begin errors++; $display("FAIL after_reset_lo got %h exp e", rl); end
    checks++; if (rh !== 32'd2) begin errors++; $display("FAIL after_reset_hi got %h exp 2", rh); end
    checks++; if (lat != 33) begin errors++; $display("FAIL after_reset_lat got %0d exp 33", lat); end
  endtask

  task automatic test_random;
    logic [31:0] av, bv, eh, el, rh, rl, prev_hi, prev_lo;
    logic o, ed0, rd0;
    int elat, lat, mode;
    run_op(1'b0, 32'd11, 32'd13, rh, rl, rd0, lat);
    prev_hi = 32'h0;
    prev_lo = 32'd143;
    checks++; if ({rh, rl} !== {prev_hi, prev_lo}) begin
      errors++; $display("FAIL rand_seed got %h exp %h", {rh, rl}, {prev_hi, prev_lo});
    end
    for (int i = 0; i < 60; i++) begin
      o    = 1'($urandom_range(1));
      av   = $urandom;
      bv   = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: bv = 32'h0;
        1: av = 32'h8000_0000;
        2: bv = 32'hFFFF_FFFF;
        3: begin av = $urandom_range(0, 300); bv = $urandom_range(1, 20); end
        4: bv = 32'h8000_0000;
        default: ;
      endcase
      model(o, av, bv, prev_hi, prev_lo, eh, el, ed0, elat);
      run_op(o, av, bv, rh, rl, rd0, lat);
      checks++; if (lat != elat) begin
        errors++; $display("FAIL rand%0d_latency op=%b a=%h b=%h got %0d exp %0d", i, o, av, bv, lat, elat);
      end
      checks++; if ({rh, rl} !== {eh, el}) begin
        errors++; $display("FAIL rand%0d_result op=%b a=%h b=%h got %h exp %h", i, o, av, bv, {rh, rl}, {eh, el});
      end
      checks++; if (rd0 !== ed0) begin
        errors++; $display("FAIL rand%0d_div0 got %b exp %b", i, rd0, ed0);
      end
      @(posedge clk);
      #1;
      checks++; if ({done_o, busy_o} !== 2'b00) begin
        errors++; $display("FAIL rand%0d_pulse got %b exp 00", i, {done_o, busy_o});
      end
      prev_hi = eh;
      prev_lo = el;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
